// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache main-memory arbiter.
package cache_arb_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned WORD_IDX_W      = 3;

  // Arbiter FSM encoding, kept as plain constants for compatibility with older users.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t FILL_I  = 2'd1;
  localparam arb_state_t FILL_D  = 2'd2;
  localparam arb_state_t WRITE_D = 2'd3;

  // Which cache was served by the most recent block fill.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/fill_word_counter.sv
// Word index counter for block fills: async clear, sync clear, enable, terminal-count flag.
module fill_word_counter
  import cache_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_IDX_W-1:0] cnt,
  output logic                  tc
);

  // Count enabled events; sync clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flag the last word of the block.
  always_comb begin
    tc = (cnt == WORD_IDX_W'(WORDS_PER_BLOCK - 1));
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared pipelined memory port between I-fill, D-fill and D write-through.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,  // active-high despite the name
  input  logic                  ic_req,
  input  logic [ADDR_W-1:0]     ic_addr,
  input  logic                  dc_req,
  input  logic                  dc_wr,
  input  logic [ADDR_W-1:0]     dc_addr,
  input  logic [15:0]           dc_wdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_data_valid,
  output logic                  ic_grant,
  output logic                  dc_grant,
  output logic                  ic_data_valid,
  output logic                  dc_data_valid,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  ic_done,
  output logic                  dc_done
);

  arb_state_t            state_q, state_d;
  req_id_t               last_served_q;
  logic [ADDR_W-1:0]     base_q;
  logic                  issue_done_q;
  logic [WORD_IDX_W-1:0] issue_cnt, ret_cnt;
  logic                  issue_tc, ret_tc;
  logic                  in_fill, issue_en, ret_en, fill_last, cnt_clr;

  // Low address bits are implied by the block/word alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr[3:0], dc_addr[0]};

  assign in_fill   = (state_q == FILL_I) || (state_q == FILL_D);
  assign issue_en  = in_fill && !issue_done_q;
  assign ret_en    = in_fill && mem_data_valid;
  assign fill_last = ret_en && ret_tc;
  assign cnt_clr   = (state_q == IDLE);

  fill_word_counter u_issue_cnt (
    .clk (clk),
    .rst (rst_n),
    .clr (cnt_clr),
    .en  (issue_en),
    .cnt (issue_cnt),
    .tc  (issue_tc)
  );

  fill_word_counter u_ret_cnt (
    .clk (clk),
    .rst (rst_n),
    .clr (cnt_clr),
    .en  (ret_en),
    .cnt (ret_cnt),
    .tc  (ret_tc)
  );

  // Next-state: arbitrate from IDLE only; fills end on the last returned word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dc_req && dc_wr) begin
          state_d = WRITE_D;
        end else if (dc_req && ic_req) begin
          state_d = (last_served_q == REQ_I) ? FILL_D : FILL_I;
        end else if (dc_req) begin
          state_d = FILL_D;
        end else if (ic_req) begin
          state_d = FILL_I;
        end
      end
      FILL_I, FILL_D: begin
        if (fill_last) state_d = IDLE;
      end
      WRITE_D: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, fairness history, latched base address and issue-saturation flag.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= IDLE;
      last_served_q <= REQ_I;
      base_q        <= '0;
      issue_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fill_last) begin
        last_served_q <= (state_q == FILL_I) ? REQ_I : REQ_D;
      end
      if (state_q == IDLE) begin
        issue_done_q <= 1'b0;
        unique case (state_d)
          WRITE_D: base_q <= {dc_addr[ADDR_W-1:1], 1'b0};
          FILL_D:  base_q <= {dc_addr[ADDR_W-1:4], 4'h0};
          FILL_I:  base_q <= {ic_addr[ADDR_W-1:4], 4'h0};
          default: base_q <= base_q;
        endcase
      end else if (issue_en && issue_tc) begin
        issue_done_q <= 1'b1;
      end
    end
  end

  // Memory port, grants and return steering, all decoded from registered state.
  always_comb begin
    mem_en        = issue_en || (state_q == WRITE_D);
    mem_wr        = (state_q == WRITE_D);
    mem_addr      = '0;
    mem_wdata     = '0;
    if (state_q == WRITE_D) begin
      mem_addr  = base_q;
      mem_wdata = dc_wdata;
    end else if (issue_en) begin
      mem_addr = {base_q[ADDR_W-1:4], issue_cnt, 1'b0};
    end
    ic_grant      = (state_q == FILL_I);
    dc_grant      = (state_q == FILL_D) || (state_q == WRITE_D);
    ic_data_valid = (state_q == FILL_I) && mem_data_valid;
    dc_data_valid = (state_q == FILL_D) && mem_data_valid;
    fill_word     = ret_en ? ret_cnt : '0;
    ic_done       = (state_q == FILL_I) && fill_last;
    dc_done       = (state_q == WRITE_D) || ((state_q == FILL_D) && fill_last);
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a small pipelined memory model.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ic_req = 1'b0;
  logic [15:0] ic_addr = '0;
  logic        dc_req = 1'b0;
  logic        dc_wr = 1'b0;
  logic [15:0] dc_addr = '0;
  logic [15:0] dc_wdata = '0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_data_valid;
  logic        ic_grant, dc_grant, ic_data_valid, dc_data_valid, ic_done, dc_done;
  logic [2:0]  fill_word;

  int total = 0;
  int bad   = 0;

  logic [3:0] pipe = '0;
  logic       spur = 1'b0;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .dc_req         (dc_req),
    .dc_wr          (dc_wr),
    .dc_addr        (dc_addr),
    .dc_wdata       (dc_wdata),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_valid (mem_data_valid),
    .ic_grant       (ic_grant),
    .dc_grant       (dc_grant),
    .ic_data_valid  (ic_data_valid),
    .dc_data_valid  (dc_data_valid),
    .fill_word      (fill_word),
    .ic_done        (ic_done),
    .dc_done        (dc_done)
  );

  // Memory model: a read issued in cycle k returns valid in cycle k+3.
  always @(negedge clk) begin
    pipe = {pipe[2:0], mem_en & ~mem_wr};
  end
  assign mem_data_valid = pipe[3] | spur;

  wire [39:0] obs = {mem_en, mem_wr, mem_addr, mem_wdata,
                     ic_grant, dc_grant, ic_data_valid, dc_data_valid, ic_done, dc_done};

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Walks one granted block fill from its first cycle to the following IDLE cycle.
  task automatic fill_sequence(input bit is_i, input logic [15:0] base, input int drop_at,
                               input string name);
    logic [39:0] exp;
    logic        v, dn;
    for (int c = 0; c < 11; c++) begin
      v   = (c >= 3);
      dn  = (c == 10);
      exp = {c < 8, 1'b0, (c < 8) ? (base | 16'(c * 2)) : 16'h0, 16'h0,
             is_i, !is_i, is_i & v, !is_i & v, is_i & dn, !is_i & dn};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", name, c, obs, exp);
      end
      if (v) begin
        total++;
        if (fill_word !== 3'(c - 3)) begin
          bad++;
          $display("FAIL %s fill_word cycle %0d: got %0d want %0d", name, c, fill_word, c - 3);
        end
      end
      if (c == drop_at) begin
        if (is_i) ic_req = 1'b0;
        else      dc_req = 1'b0;
      end
      tick();
    end
    total++;
    if ({ic_grant, dc_grant, mem_en} !== 3'b000) begin
      bad++;
      $display("FAIL %s idle after fill: got %b want 000", name, {ic_grant, dc_grant, mem_en});
    end
  endtask

  task automatic pulse_reset;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    tick();
    total++;
    if ({obs, fill_word} !== 43'h0) begin
      bad++;
      $display("FAIL reset outputs: got %h want 0", {obs, fill_word});
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({obs, fill_word} !== 43'h0) begin
      bad++;
      $display("FAIL post-reset idle: got %h want 0", {obs, fill_word});
    end
  endtask

  task automatic test_ic_fill;
    ic_req  = 1'b1;
    ic_addr = 16'h1234;
    tick();
    fill_sequence(1'b1, 16'h1230, 10, "ic_fill");
  endtask

  task automatic test_write;
    dc_req   = 1'b1;
    dc_wr    = 1'b1;
    dc_addr  = 16'h00A5;
    dc_wdata = 16'hBEEF;
    tick();
    total++;
    if (obs !== {1'b1, 1'b1, 16'h00A4, 16'hBEEF, 6'b010001}) begin
      bad++;
      $display("FAIL write cycle: got %h want %h", obs,
               {1'b1, 1'b1, 16'h00A4, 16'hBEEF, 6'b010001});
    end
    dc_req = 1'b0;
    dc_wr  = 1'b0;
    tick();
    total++;
    if (obs !== 40'h0) begin
      bad++;
      $display("FAIL write idle: got %h want 0", obs);
    end
  endtask

  task automatic test_pair;
    pulse_reset();
    ic_req  = 1'b1;
    ic_addr = 16'h2004;
    dc_req  = 1'b1;
    dc_wr   = 1'b0;
    dc_addr = 16'h3458;
    tick();
    fill_sequence(1'b0, 16'h3450, 10, "pair_d_first");
    tick();
    fill_sequence(1'b1, 16'h2000, 10, "pair_i_second");
  endtask

  task automatic test_second_pair;
    dc_req  = 1'b1;
    dc_addr = 16'h777E;
    tick();
    fill_sequence(1'b0, 16'h7770, 10, "d_alone");
    ic_req  = 1'b1;
    ic_addr = 16'hA0F0;
    dc_req  = 1'b1;
    dc_addr = 16'hB00C;
    tick();
    fill_sequence(1'b1, 16'hA0F0, 10, "pair2_i_first");
    tick();
    fill_sequence(1'b0, 16'hB000, 10, "pair2_d_second");
  endtask

  task automatic test_blocked_write;
    ic_req  = 1'b1;
    ic_addr = 16'h4441;
    tick();
    dc_req   = 1'b1;
    dc_wr    = 1'b1;
    dc_addr  = 16'h0F0F;
    dc_wdata = 16'h5A5A;
    fill_sequence(1'b1, 16'h4440, 10, "blocked_write_fill");
    tick();
    total++;
    if (obs !== {1'b1, 1'b1, 16'h0F0E, 16'h5A5A, 6'b010001}) begin
      bad++;
      $display("FAIL blocked write: got %h want %h", obs,
               {1'b1, 1'b1, 16'h0F0E, 16'h5A5A, 6'b010001});
    end
    dc_req = 1'b0;
    dc_wr  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fill;
    ic_req  = 1'b1;
    ic_addr = 16'h5678;
    tick();
    for (int i = 0; i < 5; i++) tick();
    total++;
    if ({ic_data_valid, fill_word} !== 4'b1010) begin
      bad++;
      $display("FAIL third word before reset: got %b want 1010", {ic_data_valid, fill_word});
    end
    rst_n  = 1'b1;
    ic_req = 1'b0;
    #1;
    total++;
    if ({obs, fill_word} !== 43'h0) begin
      bad++;
      $display("FAIL async reset: got %h want 0", {obs, fill_word});
    end
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({obs, fill_word} !== 43'h0) begin
        bad++;
        $display("FAIL leftover valid %0d: got %h want 0", i, {obs, fill_word});
      end
    end
    tick();
    ic_req  = 1'b1;
    ic_addr = 16'h9ABC;
    tick();
    fill_sequence(1'b1, 16'h9AB0, 10, "refill_after_reset");
  endtask

  task automatic test_spurious_drop;
    spur = 1'b1;
    #1;
    total++;
    if ({ic_data_valid, dc_data_valid, ic_done, dc_done} !== 4'b0000) begin
      bad++;
      $display("FAIL spurious valid: got %b want 0000",
               {ic_data_valid, dc_data_valid, ic_done, dc_done});
    end
    tick();
    spur    = 1'b0;
    ic_req  = 1'b1;
    ic_addr = 16'hC3C3;
    tick();
    fill_sequence(1'b1, 16'hC3C0, 2, "drop_mid_fill");
  endtask

  initial begin
    test_reset();
    test_ic_fill();
    test_write();
    test_pair();
    test_second_pair();
    test_blocked_write();
    test_reset_mid_fill();
    test_spurious_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
